// File: rtl/sdp_block_ram_if.sv
// rtl/sdp_block_ram_if.sv - write/read port bundle for sdp_block_ram
// SDP_BLOCK_RAM_OUTREG_EN adds the regce stage-2 clock enable.
interface sdp_block_ram_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11
);
  logic                     wen;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]    din;
  logic                     ren;
  logic [ADDRESS_WIDTH-1:0] raddr;
`ifdef SDP_BLOCK_RAM_OUTREG_EN
  logic                     regce;
`endif
  logic [DATA_WIDTH-1:0]    dout;

`ifdef SDP_BLOCK_RAM_OUTREG_EN
  modport master (output wen, waddr, din, ren, raddr, regce, input dout);
  modport slave  (input wen, waddr, din, ren, raddr, regce, output dout);
`else
  modport master (output wen, waddr, din, ren, raddr, input dout);
  modport slave  (input wen, waddr, din, ren, raddr, output dout);
`endif
endinterface

// File: rtl/sdp_block_ram.sv
// rtl/sdp_block_ram.sv - simple dual-port read-first block RAM, registered read
// SDP_BLOCK_RAM_OUTREG_EN adds a regce-gated second output register (latency 2).
module sdp_block_ram #(
  parameter int                    DATA_WIDTH       = 16,
  parameter int                    ADDRESS_WIDTH    = 11,
  parameter logic [DATA_WIDTH-1:0] READ_RESET_VALUE = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  sdp_block_ram_if.slave     bus
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rd1_d, rd1_q;

  // Array has no reset: writes land even while reset_n is low.
  always_ff @(posedge clock) begin
    if (bus.wen) begin
      mem[bus.waddr] <= bus.din;
    end
  end

  // Sampled before the same-edge write commits, giving read-first collisions.
  always_comb begin
    rd1_d = rd1_q;
    if (bus.ren) begin
      rd1_d = mem[bus.raddr];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd1_q <= READ_RESET_VALUE;
    end else begin
      rd1_q <= rd1_d;
    end
  end

`ifdef SDP_BLOCK_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] rd2_d, rd2_q;

  always_comb begin
    rd2_d = rd2_q;
    if (bus.regce) begin
      rd2_d = rd1_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd2_q <= READ_RESET_VALUE;
    end else begin
      rd2_q <= rd2_d;
    end
  end

  assign bus.dout = rd2_q;
`else
  assign bus.dout = rd1_q;
`endif
endmodule

// File: tb/tb_sdp_block_ram.sv
// tb/tb_sdp_block_ram.sv - directed self-checking bench for sdp_block_ram
// Build with or without SDP_BLOCK_RAM_OUTREG_EN; expected latency follows the macro.
module tb_sdp_block_ram;
  localparam int DW = 16;
  localparam int AW = 11;
`ifdef SDP_BLOCK_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [DW-1:0] rd;
  logic [DW-1:0] obs [4];

  always #5 clk = ~clk;

  sdp_block_ram_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  sdp_block_ram #(
    .DATA_WIDTH(DW),
    .ADDRESS_WIDTH(AW),
    .READ_RESET_VALUE(16'h0000)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wen   = 1'b0;
    bus.waddr = '0;
    bus.din   = '0;
    bus.ren   = 1'b0;
    bus.raddr = '0;
`ifdef SDP_BLOCK_RAM_OUTREG_EN
    bus.regce = 1'b1;
`endif
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wen = 1'b1; bus.waddr = a; bus.din = d;
    step();
    bus.wen = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus.ren = 1'b1; bus.raddr = a;
    step();
    bus.ren = 1'b0;
    repeat (LAT - 1) step();
    d = bus.dout;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (bus.dout !== 16'h0000) begin
      n_fail++; $display("FAIL reset_held dout=%h expected=%h", bus.dout, 16'h0000);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (bus.dout !== 16'h0000) begin
      n_fail++; $display("FAIL reset_release dout=%h expected=%h", bus.dout, 16'h0000);
    end
    read_word(11'd5, rd);
    n_cmp++;
    if (rd !== 16'h0000) begin
      n_fail++; $display("FAIL reset_unwritten_read dout=%h expected=%h", rd, 16'h0000);
    end
  endtask

  task automatic test_write_read();
    write_word(11'h012, 16'hBEEF);
    obs[0] = bus.dout;
    bus.ren = 1'b1; bus.raddr = 11'h012;
    step();
    bus.ren = 1'b0;
    obs[1] = bus.dout;
    step();
    obs[2] = bus.dout;
    n_cmp++;
    if (obs[LAT-1] !== 16'h0000) begin
      n_fail++; $display("FAIL write_read_early dout=%h expected=%h", obs[LAT-1], 16'h0000);
    end
    n_cmp++;
    if (obs[LAT] !== 16'hBEEF) begin
      n_fail++; $display("FAIL write_read_latency dout=%h expected=%h", obs[LAT], 16'hBEEF);
    end
  endtask

  task automatic test_back_to_back();
    bus.wen = 1'b1; bus.waddr = 11'd0; bus.din = 16'hA5A5;
    bus.ren = 1'b1; bus.raddr = 11'd2047;
    step();
    obs[0] = bus.dout;
    bus.wen = 1'b1; bus.waddr = 11'd2047; bus.din = 16'h5A5A;
    bus.ren = 1'b1; bus.raddr = 11'd0;
    step();
    obs[1] = bus.dout;
    bus.wen = 1'b0; bus.ren = 1'b0;
    step();
    obs[2] = bus.dout;
    n_cmp++;
    if (obs[LAT-1] !== 16'h0000) begin
      n_fail++; $display("FAIL b2b_first_read dout=%h expected=%h", obs[LAT-1], 16'h0000);
    end
    n_cmp++;
    if (obs[LAT] !== 16'hA5A5) begin
      n_fail++; $display("FAIL b2b_second_read dout=%h expected=%h", obs[LAT], 16'hA5A5);
    end
    read_word(11'd2047, rd);
    n_cmp++;
    if (rd !== 16'h5A5A) begin
      n_fail++; $display("FAIL b2b_top_addr dout=%h expected=%h", rd, 16'h5A5A);
    end
  endtask

  task automatic test_collision();
    write_word(11'h7FF, 16'h1111);
    bus.wen = 1'b1; bus.waddr = 11'h7FF; bus.din = 16'h2222;
    bus.ren = 1'b1; bus.raddr = 11'h7FF;
    step();
    bus.wen = 1'b0; bus.ren = 1'b0;
    repeat (LAT - 1) step();
    n_cmp++;
    if (bus.dout !== 16'h1111) begin
      n_fail++; $display("FAIL collision_old dout=%h expected=%h", bus.dout, 16'h1111);
    end
    read_word(11'h7FF, rd);
    n_cmp++;
    if (rd !== 16'h2222) begin
      n_fail++; $display("FAIL collision_new dout=%h expected=%h", rd, 16'h2222);
    end
  endtask

  task automatic test_ren_hold();
    write_word(11'd3, 16'h00AA);
    write_word(11'd4, 16'h00BB);
    read_word(11'd3, rd);
    n_cmp++;
    if (rd !== 16'h00AA) begin
      n_fail++; $display("FAIL ren_first_read dout=%h expected=%h", rd, 16'h00AA);
    end
    bus.ren = 1'b0; bus.raddr = 11'd4;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (bus.dout !== 16'h00AA) begin
        n_fail++; $display("FAIL ren_hold_cycle%0d dout=%h expected=%h", i, bus.dout, 16'h00AA);
      end
    end
    read_word(11'd4, rd);
    n_cmp++;
    if (rd !== 16'h00BB) begin
      n_fail++; $display("FAIL ren_resume dout=%h expected=%h", rd, 16'h00BB);
    end
  endtask

  task automatic test_async_reset();
    write_word(11'd10, 16'h1234);
    read_word(11'd10, rd);
    n_cmp++;
    if (rd !== 16'h1234) begin
      n_fail++; $display("FAIL async_pre dout=%h expected=%h", rd, 16'h1234);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.dout !== 16'h0000) begin
      n_fail++; $display("FAIL async_immediate dout=%h expected=%h", bus.dout, 16'h0000);
    end
    bus.wen = 1'b1; bus.waddr = 11'd20; bus.din = 16'h4321;
    bus.ren = 1'b1; bus.raddr = 11'd10;
    step();
    bus.wen = 1'b0; bus.ren = 1'b0;
    step();
    n_cmp++;
    if (bus.dout !== 16'h0000) begin
      n_fail++; $display("FAIL async_read_blocked dout=%h expected=%h", bus.dout, 16'h0000);
    end
    rst_n = 1'b1;
    read_word(11'd10, rd);
    n_cmp++;
    if (rd !== 16'h1234) begin
      n_fail++; $display("FAIL async_array_kept dout=%h expected=%h", rd, 16'h1234);
    end
    read_word(11'd20, rd);
    n_cmp++;
    if (rd !== 16'h4321) begin
      n_fail++; $display("FAIL async_write_in_reset dout=%h expected=%h", rd, 16'h4321);
    end
  endtask

`ifdef SDP_BLOCK_RAM_OUTREG_EN
  task automatic test_regce();
    read_word(11'd3, rd);
    n_cmp++;
    if (rd !== 16'h00AA) begin
      n_fail++; $display("FAIL regce_setup dout=%h expected=%h", rd, 16'h00AA);
    end
    bus.regce = 1'b0;
    bus.ren = 1'b1; bus.raddr = 11'd4;
    step();
    bus.ren = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.dout !== 16'h00AA) begin
      n_fail++; $display("FAIL regce_hold dout=%h expected=%h", bus.dout, 16'h00AA);
    end
    bus.regce = 1'b1;
    step();
    n_cmp++;
    if (bus.dout !== 16'h00BB) begin
      n_fail++; $display("FAIL regce_load dout=%h expected=%h", bus.dout, 16'h00BB);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_ren_hold();
    test_async_reset();
`ifdef SDP_BLOCK_RAM_OUTREG_EN
    test_regce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sdp_block_ram.md
Name: sdp_block_ram

Overview:
- Simple dual-port RAM: one write port and one read port on a single common clock.
- Read-first collision semantics; registered read data.
- Behavioural replacement for the vendor SDP block RAM macro. Used as the register-file and scratchpad storage primitive inside each processor core.
- Memory depth is 2^ADDRESS_WIDTH words of DATA_WIDTH bits.

Parameters:
- DATA_WIDTH, 16, word width in bits (1..72).
- ADDRESS_WIDTH, 11, address width; depth = 1 << ADDRESS_WIDTH.
- READ_RESET_VALUE, 0, value loaded into read data register(s) on reset (DATA_WIDTH bits).

Ports:
- clock  in  1  single clock for both ports.
- reset_n  in  1  asynchronous active-low reset; clears read data pipeline only.
- wen  in  1  write enable, sampled on rising clock.
- waddr  in  ADDRESS_WIDTH  write address.
- din  in  DATA_WIDTH  write data.
- ren  in  1  read enable; when low the read data register holds its value.
- raddr  in  ADDRESS_WIDTH  read address.
- dout  out  DATA_WIDTH  registered read data.

Behaviour:
- Storage: array of 2^ADDRESS_WIDTH words, all initialised to zero at time zero. reset_n never clears the array.
- Write: on posedge clock with wen=1, mem[waddr] <= din. With wen=0 the array is unchanged.
- Read, latency 1:
  - On posedge clock with ren=1, the stage-1 read register <= mem[raddr] as it was before any same-edge write.
  - With ren=0 the stage-1 register holds.
- Collision (wen=1, ren=1, waddr==raddr, same edge): dout shows the OLD contents (read_first). The new data is visible on a read issued one cycle later.
- Reset:
  - reset_n low asynchronously forces every read data register to READ_RESET_VALUE.
  - While reset_n is low, writes are still accepted into the array. Reads do not update the registers.
  - Deassertion is synchronised by the user; the first read takes effect on the first posedge with reset_n high.
- Address wrap: addresses are full-range; no out-of-range case exists.
- No X on dout after reset, even before any write (the array is zero-initialised).
- No combinational path from any input to dout.

Optional Feature:
- Macro: SDP_BLOCK_RAM_OUTREG_EN.
- Defined:
  - Adds an output pipeline register after stage 1, mirroring the vendor primitive's READ_LATENCY=2 with regce.
  - Extra input port regce (1 bit) is added after raddr. Stage 2 loads stage 1 when regce=1 and holds when regce=0.
  - dout = stage 2; read latency = 2 cycles.
  - Stage 2 is reset to READ_RESET_VALUE by reset_n.
  - Collision semantics are unchanged (old data), delayed by one more cycle.
- Undefined: no regce port; dout = stage 1; latency 1.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, then release -> dout==0 (READ_RESET_VALUE); read of addr 5 with no prior write -> dout==0x0000 one cycle later.
- Write then read: write 0xBEEF to addr 0x012; next cycle ren=1 raddr=0x012 -> dout==0xBEEF exactly 1 cycle after the read edge (2 cycles with SDP_BLOCK_RAM_OUTREG_EN).
- Collision: addr 0x7FF holds 0x1111; same edge wen=1 din=0x2222 waddr=raddr=0x7FF ren=1 -> dout==0x1111. Following read of 0x7FF -> 0x2222.
- Read enable hold: read addr 3 (=0x00AA) gives dout=0x00AA. Then ren=0 with raddr=4 (=0x00BB) for 4 cycles -> dout stays 0x00AA. Set ren=1 -> 0x00BB next cycle.
- Async reset mid-stream: dout=0x1234; assert reset_n=0 between clock edges -> dout==0 immediately, without waiting for a clock. After release, reading the same address -> 0x1234 (array not cleared).
- Boundary/back-to-back:
  - Write addresses 0 and 2047 with 0xA5A5 and 0x5A5A on consecutive cycles while reading 2047 then 0 -> first read returns the old value (0), second returns 0xA5A5.
  - With OUTREG_EN and regce=0, dout holds its prior value.
